// File: rtl/note_selector.sv
`default_nettype none
// ============================================================================
// Module      : note_selector
// Description : Conditions four raw push-buttons (synchronise + debounce +
//               rising-edge detect) and drives the registered note code
//               {a,b,c,d} for the seven-segment note decoder. Supports manual
//               stepping and a single automatic pass through the scale.
// Revision    : 1.0 - initial release
// ============================================================================
module note_selector #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int STEP_CYCLES     = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_up,
  input  logic btn_down,
  input  logic btn_sharp,
  input  logic btn_play,
  output logic a,
  output logic b,
  output logic c,
  output logic d,
  output logic ready,
  output logic playing
);

  localparam int C_DB_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int C_ST_W = $clog2(STEP_CYCLES) + 1;
  localparam logic [C_DB_W-1:0] C_DB_LAST = C_DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [C_ST_W-1:0] C_ST_LAST = C_ST_W'(STEP_CYCLES - 1);

  // Button order inside the vectors: 0=up, 1=down, 2=sharp, 3=play
  logic [3:0] w_raw;
  logic [3:0] w_press;

  assign w_raw = {btn_play, btn_sharp, btn_down, btn_up};

  for (genvar i = 0; i < 4; i++) begin : g_btn
    logic              r_meta;
    logic              r_sync;
    logic [C_DB_W-1:0] r_cnt;
    logic              r_level;
    logic              r_level_d;

    // Synchronise the raw level, then flip the accepted level only after it
    // has disagreed for DEBOUNCE_CYCLES consecutive cycles.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_meta    <= 1'b0;
        r_sync    <= 1'b0;
        r_cnt     <= '0;
        r_level   <= 1'b0;
        r_level_d <= 1'b0;
      end else begin
        r_meta    <= w_raw[i];
        r_sync    <= r_meta;
        r_level_d <= r_level;
        if (r_sync != r_level) begin
          if (r_cnt == C_DB_LAST) begin
            r_level <= ~r_level;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end else begin
          r_cnt <= '0;
        end
      end
    end

    // Press = accepted level rose; releases never pulse.
    assign w_press[i] = r_level & ~r_level_d;
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_MANUAL = 2'd1,
    S_PLAY   = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nx;
  logic [2:0]        r_note;
  logic [2:0]        w_note_nx;
  logic              r_sharp;
  logic              w_sharp_nx;
  logic [C_ST_W-1:0] r_step;
  logic [C_ST_W-1:0] w_step_nx;
  logic              r_ready;
  logic              w_change;

  logic w_up;
  logic w_down;
  logic w_sh;
  logic w_play;

  assign w_up   = w_press[0];
  assign w_down = w_press[1];
  assign w_sh   = w_press[2];
  assign w_play = w_press[3];

  // Next-state / next-note decision; play has priority in every state.
  always_comb begin
    w_state_nx = r_state;
    w_note_nx  = r_note;
    w_sharp_nx = r_sharp;
    w_step_nx  = r_step;
    case (r_state)
      S_IDLE: begin
        if (w_play) begin
          w_state_nx = S_PLAY;
          w_note_nx  = 3'd1;
          w_sharp_nx = 1'b0;
          w_step_nx  = '0;
        end else if (w_up) begin
          w_state_nx = S_MANUAL;
          w_note_nx  = 3'd1;
        end else if (w_down) begin
          w_state_nx = S_MANUAL;
          w_note_nx  = 3'd7;
        end
      end
      S_MANUAL: begin
        if (w_play) begin
          w_state_nx = S_PLAY;
          w_sharp_nx = 1'b0;
          w_step_nx  = '0;
        end else begin
          // Opposing up/down presses cancel each other out.
          if (w_up && !w_down) begin
            w_note_nx = (r_note == 3'd7) ? 3'd1 : r_note + 3'd1;
          end else if (w_down && !w_up) begin
            w_note_nx = (r_note == 3'd1) ? 3'd7 : r_note - 3'd1;
          end
          if (w_sh) begin
            w_sharp_nx = ~r_sharp;
          end
        end
      end
      S_PLAY: begin
        if (w_play) begin
          // Pause: hold the current note and restart the step timer.
          w_state_nx = S_MANUAL;
          w_step_nx  = '0;
        end else if (r_step == C_ST_LAST) begin
          w_step_nx = '0;
          if (r_note == 3'd7) begin
            // Single pass: leaving Si ends playback with a blank display.
            w_state_nx = S_IDLE;
            w_note_nx  = 3'd0;
            w_sharp_nx = 1'b0;
          end else begin
            w_note_nx = r_note + 3'd1;
          end
        end else begin
          w_step_nx = r_step + 1'b1;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_note_nx  = 3'd0;
        w_sharp_nx = 1'b0;
        w_step_nx  = '0;
      end
    endcase
  end

  assign w_change = ({w_note_nx, w_sharp_nx} != {r_note, r_sharp});

  // State, note code and ready pulse registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_note  <= 3'd0;
      r_sharp <= 1'b0;
      r_step  <= '0;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_note  <= w_note_nx;
      r_sharp <= w_sharp_nx;
      r_step  <= w_step_nx;
      r_ready <= w_change;
    end
  end

  assign {a, b, c} = r_note;
  assign d         = r_sharp;
  assign ready     = r_ready;
  assign playing   = (r_state == S_PLAY);

endmodule
`default_nettype wire
